branch_resolve_queue: RTL and testbench

In-order branch resolution queue: the update-side counterpart to the gshare predictor. Fetch pushes every predicted control-transfer instruction (address, predicted direction and target, GHR snapshot). Execute resolves the oldest entry; the block compares outcome against prediction, drives the predictor's training port (`update_address`, `branch_taken`, GHR), and raises a one-cycle flush/redirect on misprediction, discarding all younger wrong-path entries.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/brq_fifo.sv | 51 +++++
 rtl/branch_resolve_queue.sv | 118 +++++++++++
 tb/tb_branch_resolve_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Types and constants shared by the gshare predictor and the branch resolve queue.
package bp_pkg;

  localparam int BP_ADDR_W = 8;
  localparam int BP_GHR_W  = 8;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [BP_ADDR_W-1:0] address;
    logic                 pred;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_GHR_W-1:0]  ghr;
  } bp_entry_t;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/brq_fifo.sv
// Entry storage for the branch resolve queue: circular buffer with wrap-bit pointers
// and a single-cycle clear that empties the queue.
module brq_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  bp_entry_t              wdata,
  output bp_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  // clear wins over any push or pop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop)  head_ptr <= head_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr[IDX_W-1:0]] <= wdata;
  end

  assign head  = mem[head_ptr[IDX_W-1:0]];
  assign count = tail_ptr - head_ptr;
  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_ptr[IDX_W-1:0] == tail_ptr[IDX_W-1:0]) &&
                 (head_ptr[IDX_W] != tail_ptr[IDX_W]);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: trains the predictor on each resolved branch and
// flushes all younger entries with a redirect when the oldest one was mispredicted.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = BP_ADDR_W,
  parameter int GHR_W  = BP_GHR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [6:0]             push_opcode,
  input  logic [ADDR_W-1:0]      push_address,
  input  logic                   push_pred,
  input  logic [ADDR_W-1:0]      push_target,
  input  logic [GHR_W-1:0]       push_ghr,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic [ADDR_W-1:0]      resolve_target,
  output logic                   update,
  output logic [ADDR_W-1:0]      update_address,
  output logic                   branch_taken,
  output logic [GHR_W-1:0]       update_ghr,
  output logic                   flush,
  output logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   underflow
);

  function automatic logic [ADDR_W-1:0] fallthrough_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

  bp_entry_t         push_entry_p0;
  bp_entry_t         head_p0;
  logic              full_p0;
  logic              empty_p0;
  logic              push_fire_p0;
  logic              vld_p0;
  logic              mispredict_p0;
  logic [ADDR_W-1:0] redirect_p0;

  logic              vld_p1;
  logic [ADDR_W-1:0] address_p1;
  logic              taken_p1;
  logic [GHR_W-1:0]  ghr_p1;
  logic              flush_p1;
  logic [ADDR_W-1:0] redirect_p1;
  logic              underflow_p1;

  // p0: accept/filter pushes, compare the head entry against the outcome
  always_comb begin
    push_entry_p0         = '0;
    push_entry_p0.address = push_address;
    push_entry_p0.pred    = push_pred;
    push_entry_p0.target  = push_target;
    push_entry_p0.ghr     = push_ghr;
  end

  assign push_ready    = ~full_p0;
  assign push_fire_p0  = push_valid & push_ready & is_ctrl_op(push_opcode);
  assign vld_p0        = resolve_valid & ~empty_p0;
  assign mispredict_p0 = vld_p0 &
                         ((resolve_taken != head_p0.pred) |
                          (resolve_taken & (resolve_target != head_p0.target)));
  assign redirect_p0   = resolve_taken ? resolve_target : fallthrough_pc(head_p0.address);

  brq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (mispredict_p0),
    .push  (push_fire_p0),
    .pop   (vld_p0),
    .wdata (push_entry_p0),
    .head  (head_p0),
    .count (count),
    .full  (full_p0),
    .empty (empty_p0)
  );

  // p1: registered training and redirect outputs, one-cycle strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1       <= 1'b0;
      flush_p1     <= 1'b0;
      underflow_p1 <= 1'b0;
      address_p1   <= '0;
      taken_p1     <= 1'b0;
      ghr_p1       <= '0;
      redirect_p1  <= '0;
    end else begin
      vld_p1   <= vld_p0;
      flush_p1 <= mispredict_p0;
      if (resolve_valid & empty_p0) underflow_p1 <= 1'b1;
      if (vld_p0) begin
        address_p1  <= head_p0.address;
        taken_p1    <= resolve_taken;
        ghr_p1      <= head_p0.ghr;
        redirect_p1 <= redirect_p0;
      end
    end
  end

  assign update         = vld_p1;
  assign update_address = address_p1;
  assign branch_taken   = taken_p1;
  assign update_ghr     = ghr_p1;
  assign flush          = flush_p1;
  assign redirect_pc    = redirect_p1;
  assign empty          = empty_p0;
  assign underflow      = underflow_p1;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a scoreboard of expected update pulses.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [6:0] push_opcode = '0;
  logic [7:0] push_address = '0;
  logic       push_pred = 1'b0;
  logic [7:0] push_target = '0;
  logic [7:0] push_ghr = '0;
  logic       resolve_valid = 1'b0;
  logic       resolve_taken = 1'b0;
  logic [7:0] resolve_target = '0;
  logic       update;
  logic [7:0] update_address;
  logic       branch_taken;
  logic [7:0] update_ghr;
  logic       flush;
  logic [7:0] redirect_pc;
  logic [2:0] count;
  logic       empty;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic       taken;
    logic [7:0] ghr;
    logic       flush;
    logic [7:0] redir;
  } exp_t;

  exp_t sb[$];

  localparam logic [6:0] B    = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ALU  = 7'b0110011;

  branch_resolve_queue #(.DEPTH(4), .ADDR_W(8), .GHR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .push_opcode    (push_opcode),
    .push_address   (push_address),
    .push_pred      (push_pred),
    .push_target    (push_target),
    .push_ghr       (push_ghr),
    .resolve_valid  (resolve_valid),
    .resolve_taken  (resolve_taken),
    .resolve_target (resolve_target),
    .update         (update),
    .update_address (update_address),
    .branch_taken   (branch_taken),
    .update_ghr     (update_ghr),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .count          (count),
    .empty          (empty),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every update pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (update) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got address %0h expected no update", update_address);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("update_address", update_address, e.addr);
          chk("branch_taken", branch_taken, e.taken);
          chk("update_ghr", update_ghr, e.ghr);
          chk("flush", flush, e.flush);
          if (e.flush) chk("redirect_pc", redirect_pc, e.redir);
        end
      end else if (flush) begin
        chk("flush_without_update", flush, 1'b0);
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic do_push(input logic [6:0] op, input logic [7:0] addr, input logic pred,
                         input logic [7:0] tgt, input logic [7:0] ghr);
    push_valid = 1'b1; push_opcode = op; push_address = addr;
    push_pred = pred; push_target = tgt; push_ghr = ghr;
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  task automatic expect_upd(input logic [7:0] addr, input logic taken, input logic [7:0] ghr,
                            input logic fl, input logic [7:0] redir);
    exp_t e;
    e.addr = addr; e.taken = taken; e.ghr = ghr; e.flush = fl; e.redir = redir;
    sb.push_back(e);
  endtask

  task automatic do_resolve(input logic taken, input logic [7:0] tgt);
    resolve_valid = 1'b1; resolve_taken = taken; resolve_target = tgt;
    @(posedge clk); #1;
    resolve_valid = 1'b0;
  endtask

  task automatic drained(input string name);
    @(negedge clk); #1;
    chk(name, sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_update", update, 0);
    chk("rst_flush", flush, 0);
    chk("rst_empty", empty, 1);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_redirect", redirect_pc, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // correctly predicted not-taken branch
    do_push(B, 8'h04, 1'b0, 8'h00, 8'h00);
    chk("t1_count", count, 1);
    expect_upd(8'h04, 1'b0, 8'h00, 1'b0, 8'h08);
    do_resolve(1'b0, 8'h00);
    chk("t1_empty", empty, 1);
    drained("t1_drained");

    // taken with wrong target flushes the younger entry
    do_push(JAL, 8'h10, 1'b1, 8'h40, 8'h11);
    do_push(B, 8'h14, 1'b0, 8'h00, 8'h12);
    chk("t2_count_before", count, 2);
    expect_upd(8'h10, 1'b1, 8'h11, 1'b1, 8'h44);
    do_resolve(1'b1, 8'h44);
    chk("t2_count_after", count, 0);
    drained("t2_drained");

    // predicted taken, actually not taken: fall-through wraps
    do_push(JALR, 8'hFC, 1'b1, 8'h80, 8'h22);
    expect_upd(8'hFC, 1'b0, 8'h22, 1'b1, 8'h00);
    do_resolve(1'b0, 8'h00);
    chk("t3_empty", empty, 1);
    drained("t3_drained");

    // fill, refuse a fifth push, then four back-to-back resolves
    for (int i = 0; i < 4; i++) do_push(B, 8'h20 + 8'(4 * i), 1'b0, 8'h00, 8'h30 + 8'(i));
    chk("t4_full_ready", push_ready, 0);
    chk("t4_full_count", count, 4);
    do_push(B, 8'h30, 1'b0, 8'h00, 8'h34);
    chk("t4_drop_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      expect_upd(8'h20 + 8'(4 * i), 1'b0, 8'h30 + 8'(i), 1'b0, 8'h00);
      do_resolve(1'b0, 8'h00);
    end
    chk("t4_empty", empty, 1);
    drained("t4_drained");

    // simultaneous push and correct resolve keeps occupancy
    do_push(B, 8'h50, 1'b0, 8'h00, 8'h41);
    push_valid = 1'b1; push_opcode = B; push_address = 8'h54; push_pred = 1'b0;
    push_target = 8'h00; push_ghr = 8'h42;
    expect_upd(8'h50, 1'b0, 8'h41, 1'b0, 8'h00);
    do_resolve(1'b0, 8'h00);
    push_valid = 1'b0;
    chk("t5_count_same", count, 1);
    expect_upd(8'h54, 1'b0, 8'h42, 1'b0, 8'h00);
    do_resolve(1'b0, 8'h00);
    drained("t5_drained");

    // mispredict discards a push accepted in the same cycle
    do_push(B, 8'h60, 1'b0, 8'h00, 8'h43);
    push_valid = 1'b1; push_opcode = B; push_address = 8'h64; push_pred = 1'b0;
    push_target = 8'h00; push_ghr = 8'h44;
    expect_upd(8'h60, 1'b1, 8'h43, 1'b1, 8'h70);
    do_resolve(1'b1, 8'h70);
    push_valid = 1'b0;
    chk("t6_count_flushed", count, 0);
    drained("t6_drained");

    // non-control opcode is filtered; resolve on empty sets underflow only
    do_push(ALU, 8'h90, 1'b0, 8'h00, 8'h00);
    chk("t7_filtered_count", count, 0);
    chk("t7_filtered_ready", push_ready, 1);
    do_resolve(1'b0, 8'h00);
    chk("t7_underflow", underflow, 1);
    chk("t7_count", count, 0);
    drained("t7_drained");

    // reset mid-operation with a resolve pulse on the outputs
    for (int i = 0; i < 3; i++) do_push(B, 8'hA0 + 8'(4 * i), 1'b0, 8'h00, 8'h50);
    chk("t8_count_before", count, 3);
    do_resolve(1'b0, 8'h00);
    chk("t8_update_live", update, 1);
    #1 rst = 1'b0;
    #1;
    chk("t8_update", update, 0);
    chk("t8_flush", flush, 0);
    chk("t8_address", update_address, 0);
    chk("t8_ghr", update_ghr, 0);
    chk("t8_empty", empty, 1);
    chk("t8_count", count, 0);
    chk("t8_underflow", underflow, 0);
    chk("t8_ready", push_ready, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // bounded wait for any outstanding expectation
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("final_scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
